dual_core_data_memory: RTL
==========================

Name: dual_core_data_memory

Overview:
- Shared data-memory responder for the two processor cores: the memory end of the core's mem_read / mem_write / address / data interface.
- Each core issues a word read or write and stalls until this block pulses that core's ready.
- Arbitrates round-robin between core 0 and core 1 and models a fixed access latency.
- Sits beside the cores in the processor top, replacing per-core data memories.

Parameters:
reg_width, 16, data word and address width in bits
DEPTH, 256, number of words in the array (power of two)
MEM_LATENCY, 2, cycles spent in ACCESS (legal range 1..15)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
mem_read0  input  2  core 0 read request: 2'b00 idle, any non-zero value = word read
mem_write0  input  1  core 0 write request
addr0  input  reg_width  core 0 word address (AR output)
wdata0  input  reg_width  core 0 write data
rdata0  output  reg_width  read data to core 0 (core DM_datain)
ready0  output  1  one-cycle completion pulse to core 0
mem_read1, mem_write1, addr1, wdata1, rdata1, ready1: identical set for core 1
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM to IDLE.
  - ready0=ready1=0, busy=0, rdata0=rdata1=0.
  - last_grant=1, so core 0 wins the first tie.
  - Array contents are not reset.
- Request definition: req_n = (mem_read_n != 0) | mem_write_n. Cores hold address, data and request stable until they see their ready.
- FSM states:
  - IDLE: sample req0 and req1.
    - Neither asserted: stay in IDLE.
    - Exactly one asserted: grant that core.
    - Both asserted: grant the core != last_grant.
    - On a grant: latch gid, addr (low log2(DEPTH) bits), wdata and op; update last_grant; load cnt=MEM_LATENCY-1; go to ACCESS.
  - ACCESS: decrement cnt each cycle. On the edge where cnt==0:
    - Write: commit mem[addr]=wdata.
    - Read: latch mem[addr] into rdata_gid.
    - Go to RESPOND.
  - RESPOND: ready_gid=1 for exactly this cycle; go to IDLE. Requests are not sampled in RESPOND.
- Latency: request first visible at edge k → ready high during cycle k+MEM_LATENCY+1.
  - Back-to-back throughput: one access per MEM_LATENCY+2 cycles.
- Read and write asserted together: treated as a write. rdata_gid is loaded with wdata in the same edge, giving write-through readback.
- rdata_n holds its value until the next completed read or write for port n. The other port's rdata is untouched.
- Addresses at or above DEPTH wrap: only the low log2(DEPTH) bits are used.
- Request dropped during ACCESS: the access still completes, a write is still committed, and ready still pulses.
- Reset asserted mid-access: the access is aborted, no write is committed, no ready pulse occurs, and rdata is cleared.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1. Neither core waits more than one foreign access.

Decomposition:
- Shared package holds:
  - FSM state enum {IDLE, ACCESS, RESPOND}.
  - mem_read encoding constants MR_IDLE=2'b00 and MR_READ=2'b01.
  - Default reg_width.
- One natural sub-module: rr_arbiter2.
  - Two-request round-robin grant with a last_grant register, enabled only in IDLE.
  - The memory array and FSM stay in the top.

Test Plan:
- Reset, then core 0 writes 16'hA5A5 to addr 5, then reads addr 5 (MEM_LATENCY=2) → ready0 pulses 3 cycles after each request; rdata0=16'hA5A5; ready1 never asserts.
- Both cores request in the same cycle, core 0 reading addr 3 and core 1 writing 16'h1234 to addr 3 → core 0 is served first and returns the old mem[3]. Core 1's write completes 4 cycles later. A following core-0 read of addr 3 returns 16'h1234.
- Both cores hold continuous reads for 8 accesses → grant order is 0,1,0,1,…; ready pulses alternate, spaced 4 cycles apart; each ready is exactly one cycle wide.
- Core 1 writes 16'h00FF to addr 16'h0105 with DEPTH=256 → a read of addr 5 returns 16'h00FF (wrap-around).
- Core 0 writes 16'hBEEF to addr 7, and reset is pulsed low during ACCESS → no ready0, busy=0, rdata0=0 immediately. A subsequent read of addr 7 returns the pre-write value.
- Core 0 asserts mem_read0=2'b01 and mem_write0=1 with wdata 16'h0F0F at addr 9 → treated as a write; rdata0=16'h0F0F at the ready0 pulse; mem[9]=16'h0F0F.

Source files
------------

// File: rtl/dual_core_data_memory_pkg.sv
// rtl/dual_core_data_memory_pkg.sv - shared types and constants for the dual-core data memory
package dual_core_data_memory_pkg;

    // Access sequencer states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    // Core mem_read encoding: any value other than MR_IDLE requests a word read
    localparam logic [1:0] MR_IDLE = 2'b00;
    localparam logic [1:0] MR_READ = 2'b01;

    localparam int DEFAULT_REG_WIDTH = 16;

endpackage

// File: rtl/dual_core_data_memory_rr_arbiter2.sv
// rtl/dual_core_data_memory_rr_arbiter2.sv - two-request round-robin arbiter
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   en                    grant accepted this cycle (last_grant advances only then)
//   req0, req1            requests from core 0 / core 1
//   grant_valid, grant_id a request is present and which core wins
module rr_arbiter2 (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic grant_valid,
    output logic grant_id
);

    // Reset value of 1 lets core 0 win the first tie
    logic last_grant;

    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = req1;
        if (req0 && req1) begin
            grant_id = ~last_grant;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= 1'b1;
        end else if (en && grant_valid) begin
            last_grant <= grant_id;
        end
    end

endmodule

// File: rtl/dual_core_data_memory.sv
// rtl/dual_core_data_memory.sv - shared two-core data memory with round-robin arbitration and fixed latency
//
// Ports:
//   clk, reset                         clock, asynchronous active-low reset
//   mem_read0/1, mem_write0/1          per-core read (non-zero) / write requests, held until ready
//   addr0/1, wdata0/1                  per-core word address and write data
//   rdata0/1                           per-core read data, held until that core's next completed access
//   ready0/1                           one-cycle completion pulse per core
//   busy                               sequencer is not idle
module dual_core_data_memory
    import dual_core_data_memory_pkg::*;
#(
    parameter int reg_width   = DEFAULT_REG_WIDTH,
    parameter int DEPTH       = 256,
    parameter int MEM_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           mem_read0,
    input  logic                 mem_write0,
    input  logic [reg_width-1:0] addr0,
    input  logic [reg_width-1:0] wdata0,
    output logic [reg_width-1:0] rdata0,
    output logic                 ready0,
    input  logic [1:0]           mem_read1,
    input  logic                 mem_write1,
    input  logic [reg_width-1:0] addr1,
    input  logic [reg_width-1:0] wdata1,
    output logic [reg_width-1:0] rdata1,
    output logic                 ready1,
    output logic                 busy
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

    state_t                 state, state_next;
    logic                   gid;
    logic [AW-1:0]          addr_q;
    logic [reg_width-1:0]   wdata_q;
    logic                   op_write;
    logic [3:0]             cnt;
    logic                   req0, req1;
    logic                   grant_valid, grant_id;
    logic                   access_done;
    logic [reg_width-1:0]   mem [DEPTH];

    // Upper address bits are deliberately ignored: addresses wrap modulo DEPTH
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr0[reg_width-1:AW], addr1[reg_width-1:AW]};

    assign req0        = (mem_read0 != MR_IDLE) | mem_write0;
    assign req1        = (mem_read1 != MR_IDLE) | mem_write1;
    assign access_done = (state == ACCESS) && (cnt == 4'd0);

    rr_arbiter2 u_arb (
        .clk         (clk),
        .reset       (reset),
        .en          (state == IDLE),
        .req0        (req0),
        .req1        (req1),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid) state_next = ACCESS;
            ACCESS:  if (cnt == 4'd0) state_next = RESPOND;
            RESPOND: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            gid      <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            op_write <= 1'b0;
            cnt      <= 4'd0;
            rdata0   <= '0;
            rdata1   <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && grant_valid) begin
                gid      <= grant_id;
                addr_q   <= grant_id ? addr1[AW-1:0] : addr0[AW-1:0];
                wdata_q  <= grant_id ? wdata1 : wdata0;
                op_write <= grant_id ? mem_write1 : mem_write0;
                cnt      <= CNT_LOAD;
            end else if (state == ACCESS && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            // Writes return their own data (write-through), so a combined
            // read+write hands the core back what it just stored
            if (access_done) begin
                if (gid) rdata1 <= op_write ? wdata_q : mem[addr_q];
                else     rdata0 <= op_write ? wdata_q : mem[addr_q];
            end
        end
    end

    // Array is not reset; an asynchronous reset forces IDLE first, so an
    // aborted access never reaches this commit
    always_ff @(posedge clk) begin
        if (access_done && op_write) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign ready0 = (state == RESPOND) && !gid;
    assign ready1 = (state == RESPOND) &&  gid;
    assign busy   = (state != IDLE);

endmodule
